// File: rtl/addmulor_pkg.sv
// Shared constants and types for the ((d + a) * b) | c pipeline and its
// issue/drain companions.
package addmulor_pkg;

  localparam int ADDMULOR_WIDTH   = 9;
  localparam int ADDMULOR_LATENCY = 3;

  typedef logic [ADDMULOR_WIDTH-1:0] addmulor_data_t;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int addmulor_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a one-entry store still needs a one-bit pointer.
  function automatic int addmulor_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/addmulor_result_fifo.sv
// Registered, in-order result store. Head is visible the cycle after the push
// edge; pointers wrap modulo DEPTH so DEPTH need not be a power of two.
module addmulor_result_fifo
  import addmulor_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ADDMULOR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 head_data,
  output logic                             empty,
  output logic [addmulor_cnt_w(DEPTH)-1:0] count
);

  localparam int PW = addmulor_ptr_w(DEPTH);
  localparam int CW = addmulor_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= {PW{1'b0}};
      rd_ptr  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/addmulor_result_drain.sv
// Credit-based drain for the fixed-latency addmulor pipeline: tracks in-flight
// validity, captures results into a FIFO and presents them on valid/ready.
module addmulor_result_drain
  import addmulor_pkg::*;
#(
  parameter int WIDTH   = ADDMULOR_WIDTH,
  parameter int LATENCY = ADDMULOR_LATENCY,
  parameter int DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  logic [WIDTH-1:0]                 pipe_out,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [WIDTH-1:0]                 m_data,
  output logic [addmulor_cnt_w(DEPTH)-1:0] outstanding,
  output logic                             overflow_err
);

  localparam int CW = addmulor_cnt_w(DEPTH);

  logic [LATENCY-1:0] vld;
  logic               fire;
  logic               pop;
  logic               push;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      outstanding_nxt;

  assign fire = issue_valid && issue_ready;
  assign pop  = m_valid && m_ready;
  assign push = vld[LATENCY-1];

  // The last vld stage lines up with the cycle pipe_out carries the result.
  generate
    if (LATENCY == 1) begin : g_vld_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= 1'b0;
        end else begin
          vld <= fire;
        end
      end
    end else begin : g_vld_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= {LATENCY{1'b0}};
        end else begin
          vld <= {vld[LATENCY-2:0], fire};
        end
      end
    end
  endgenerate

  always_comb begin
    outstanding_nxt = outstanding;
    if (fire && !pop) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (pop && !fire) begin
      outstanding_nxt = outstanding - CW'(1);
    end else begin
      outstanding_nxt = outstanding;
    end
  end

  // issue_ready is a flop so it has no path from issue_valid or m_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= {CW{1'b0}};
      issue_ready <= (DEPTH >= 1);
    end else begin
      outstanding <= outstanding_nxt;
      issue_ready <= (outstanding_nxt < CW'(DEPTH));
    end
  end

  assign fifo_full = (fifo_count == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_err <= 1'b1;
    end else begin
      overflow_err <= overflow_err;
    end
  end

  addmulor_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pipe_out),
    .pop       (pop),
    .head_data (m_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid = !fifo_empty;

endmodule

// File: tb/tb_addmulor_result_drain.sv
// Scoreboard bench for addmulor_result_drain with a behavioural model of the
// 3-stage ((d + a) * b) | c pipeline feeding pipe_out.
`timescale 1ns/1ps
module tb_addmulor_result_drain;
  import addmulor_pkg::*;

  localparam int W     = 9;
  localparam int DEPTH = 4;
  localparam int CW    = addmulor_cnt_w(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          overflow_err;
  logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;
  logic [W-1:0]  pipe_out;
  logic [W-1:0]  m_data;
  logic [CW-1:0] outstanding;

  logic [W-1:0]  s0, s1, s2, b1, c1, c2;
  logic [W-1:0]  exp_q[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            fire_cnt = 0;
  int            pop_cnt = 0;
  int            ready_bad = 0;
  int            max_out = 0;

  always #5 clk = ~clk;

  // Behavioural pipeline: no valid, no stall, samples operands every edge.
  always @(posedge clk) begin
    s0 <= d + a;
    b1 <= b;
    c1 <= c;
    s1 <= s0 * b1;
    c2 <= c1;
    s2 <= s1 | c2;
  end
  assign pipe_out = s2;

  addmulor_result_drain #(
    .WIDTH   (W),
    .LATENCY (3),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .pipe_out     (pipe_out),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .outstanding  (outstanding),
    .overflow_err (overflow_err)
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] ai, di, bi, ci);
    logic [W-1:0] sum;
    logic [W-1:0] prod;
    sum  = di + ai;
    prod = sum * bi;
    return prod | ci;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_ops(input logic [W-1:0] ai, di, bi, ci);
    a = ai;
    d = di;
    b = bi;
    c = ci;
  endtask

  // Scoreboard: push on fire, pop and compare on each accepted head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (issue_valid && issue_ready) begin
        exp_q.push_back(model(a, d, b, c));
        fire_cnt++;
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      if (issue_ready !== (outstanding < CW'(DEPTH))) begin
        ready_bad++;
      end
      if (int'(outstanding) > max_out) begin
        max_out = int'(outstanding);
      end
    end
  end

  task automatic run_single(input logic [W-1:0] ai, di, bi, ci, input logic [W-1:0] expected);
    cycle();
    issue_valid = 1'b1;
    m_ready     = 1'b1;
    set_ops(ai, di, bi, ci);
    settle();
    cycle();
    issue_valid = 1'b0;
    settle();
    check("single_out_busy", 32'(outstanding), 32'd1);
    for (int j = 1; j <= 5; j++) begin
      cycle();
      settle();
      check("single_valid", 32'(m_valid), 32'(j == 3));
      if (j == 3) check("single_data", 32'(m_data), 32'(expected));
      if (j == 4) check("single_out_free", 32'(outstanding), 32'd0);
    end
  endtask

  task automatic drain(input int budget);
    m_ready     = 1'b1;
    issue_valid = 1'b0;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      cycle();
      settle();
    end
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int first_valid;
    int stale;
    logic [W-1:0] head;

    repeat (3) cycle();
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_overflow", 32'(overflow_err), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);

    run_single(9'd1, 9'd2, 9'd3, 9'd4, 9'd13);
    run_single(9'd300, 9'd300, 9'd2, 9'd0, 9'd176);

    // Back-pressure: credits run out after DEPTH fires.
    m_ready  = 1'b0;
    fire_cnt = 0;
    pop_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      issue_valid = 1'b1;
      set_ops(W'(i + 10), W'(i), 9'd3, W'(i * 2));
      settle();
    end
    cycle();
    issue_valid = 1'b0;
    settle();
    check("bp_fires", 32'(fire_cnt), 32'd4);
    check("bp_issue_ready", 32'(issue_ready), 32'd0);
    check("bp_outstanding", 32'(outstanding), 32'd4);
    check("bp_m_valid", 32'(m_valid), 32'd1);
    head = exp_q.size() != 0 ? exp_q[0] : 9'd0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", 32'(m_data), 32'(head));
      cycle();
      settle();
    end
    cycle();
    m_ready = 1'b1;
    settle();
    cycle();
    settle();
    check("bp_ready_after_pop", 32'(issue_ready), 32'd1);
    drain(10);
    check("bp_pops", 32'(pop_cnt), 32'd4);

    // Full throughput with m_ready high.
    fire_cnt    = 0;
    pop_cnt     = 0;
    max_out     = 0;
    first_valid = -1;
    m_ready     = 1'b1;
    for (int i = 0; i < 80 && pop_cnt < 16; i++) begin
      cycle();
      if (fire_cnt < 16) begin
        issue_valid = 1'b1;
        set_ops(W'(i * 7 + 1), W'(i * 3 + 5), W'(i + 2), W'(i * 11));
      end else begin
        issue_valid = 1'b0;
      end
      settle();
      if (m_valid && first_valid < 0) first_valid = i;
    end
    issue_valid = 1'b0;
    check("tp_first_valid", 32'(first_valid), 32'd4);
    check("tp_pops", 32'(pop_cnt), 32'd16);
    check("tp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("tp_max_outstanding", 32'(max_out), 32'd4);
    check("tp_overflow", 32'(overflow_err), 32'd0);

    // Pushes land on the same edges as pops while the store holds entries.
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      issue_valid = (i == 0 || i == 1 || i == 6 || i == 7);
      set_ops(W'(i + 40), W'(i * 5), W'(i + 1), W'(i));
      if (i == 9) m_ready = 1'b1;
      settle();
      if (i == 9) check("sim_outstanding_full", 32'(outstanding), 32'd4);
      if (i == 10) check("sim_outstanding_after", 32'(outstanding), 32'd3);
    end
    drain(10);
    check("sim_overflow", 32'(overflow_err), 32'd0);

    // Asynchronous reset with 2 stored and 2 in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (i == 8) begin
        check("pre_rst_outstanding", 32'(outstanding), 32'd4);
        issue_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_outstanding", 32'(outstanding), 32'd0);
        check("mid_rst_issue_ready", 32'(issue_ready), 32'd1);
      end else begin
        issue_valid = (i == 0 || i == 1 || i == 6 || i == 7);
        set_ops(W'(i + 90), W'(i), W'(i + 3), W'(i * 9));
        settle();
      end
    end
    repeat (2) cycle();
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    stale   = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      settle();
      if (m_valid) stale++;
    end
    check("no_stale_results", 32'(stale), 32'd0);
    run_single(9'd5, 9'd6, 9'd7, 9'd8, 9'd77);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ready_decode", 32'(ready_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
